// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a captured bit pattern MSB-first, repeated
// with optional idle gaps, and qualifies each bit with valid. Ends with a done pulse.
module seq_pattern_gen #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int REP_W   = 8,
    parameter int GAP_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [REP_W-1:0]   reps,
    input  logic [GAP_W-1:0]   gap,
    output logic               a_out,
    output logic               valid,
    output logic               busy,
    output logic               done
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [IDX_W-1:0]   top_q, top_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [REP_W-1:0]   rem_q, rem_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   cnt_q, cnt_d;

    logic [LEN_W-1:0]   leff;
    logic [IDX_W-1:0]   leff_top;

    // Over-long requests are clamped so the index never leaves the pattern register.
    assign leff     = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    assign leff_top = IDX_W'(leff - 1'b1);

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d = state_q;
        pat_d   = pat_q;
        top_d   = top_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d = pattern;
                    gap_d = gap;
                    rem_d = reps;
                    top_d = leff_top;
                    idx_d = leff_top;
                    state_d = (leff == '0 || reps == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (idx_q == '0) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == REP_W'(1)) begin
                        state_d = DONE;
                    end else if (gap_q != '0) begin
                        state_d = GAP;
                        cnt_d   = gap_q;
                    end else begin
                        idx_d = top_q;
                    end
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_W'(1)) begin
                    state_d = SHIFT;
                    idx_d   = top_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they are registered yet
    // line up with the state being entered: the first bit appears right after start.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            top_q   <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            a_out   <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            top_q   <= top_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            a_out   <= (state_d == SHIFT) && pat_d[idx_d];
            valid   <= (state_d == SHIFT);
            busy    <= (state_d == SHIFT) || (state_d == GAP);
            done    <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: a per-cycle vector table for the main
// scenarios plus a hand-written mid-transfer reset sequence.
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [7:0] reps;
    logic [3:0] gap;
    logic       a_out, valid, busy, done;

    int checks   = 0;
    int failures = 0;

    seq_pattern_gen #(
        .MAX_LEN(8), .LEN_W(4), .REP_W(8), .GAP_W(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .pattern(pattern),
        .len    (len),
        .reps   (reps),
        .gap    (gap),
        .a_out  (a_out),
        .valid  (valid),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Inputs applied before an edge, outputs {a_out,valid,busy,done} expected after it.
    typedef struct {
        logic       rst;
        logic       start;
        logic [7:0] pattern;
        logic [3:0] len;
        logic [7:0] reps;
        logic [3:0] gap;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic [7:0] p, input logic [3:0] l,
                       input logic [7:0] rp, input logic [3:0] g, input logic [3:0] e,
                       input string nm);
        vec_t v;
        v.rst = r; v.start = s; v.pattern = p; v.len = l;
        v.reps = rp; v.gap = g; v.exp = e; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        logic [8:0] s101;
        logic [7:0] sa5;
        logic [7:0] got;
        int         nbits;
        logic       seen_done;

        rst = 1'b1; start = 1'b0; pattern = '0; len = '0; reps = '0; gap = '0;

        // Reset held with start asserted, then released.
        add(1, 1, 8'h05, 3, 3, 0, 4'b0000, "rst_hold0");
        add(1, 1, 8'h05, 3, 3, 0, 4'b0000, "rst_hold1");
        add(0, 0, 8'h05, 3, 3, 0, 4'b0000, "rst_release");
        add(0, 0, 8'h05, 3, 3, 0, 4'b0000, "rst_idle");

        // "101" three times back to back.
        s101 = 9'b101101101;
        add(0, 1, 8'h05, 3, 3, 0, 4'b1110, "b2b_bit0");
        for (int i = 1; i < 9; i++)
            add(0, 0, 8'h05, 3, 3, 0, {s101[8-i], 3'b110}, "b2b_bit");
        add(0, 0, 8'h05, 3, 3, 0, 4'b0001, "b2b_done");
        add(0, 0, 8'h05, 3, 3, 0, 4'b0000, "b2b_idle");

        // Two repetitions of 110 separated by a two-cycle gap.
        add(0, 1, 8'h06, 3, 2, 2, 4'b1110, "gap_bit0");
        add(0, 0, 8'h06, 3, 2, 2, 4'b1110, "gap_bit1");
        add(0, 0, 8'h06, 3, 2, 2, 4'b0110, "gap_bit2");
        add(0, 0, 8'h06, 3, 2, 2, 4'b0010, "gap_idle0");
        add(0, 0, 8'h06, 3, 2, 2, 4'b0010, "gap_idle1");
        add(0, 0, 8'h06, 3, 2, 2, 4'b1110, "gap_bit3");
        add(0, 0, 8'h06, 3, 2, 2, 4'b1110, "gap_bit4");
        add(0, 0, 8'h06, 3, 2, 2, 4'b0110, "gap_bit5");
        add(0, 0, 8'h06, 3, 2, 2, 4'b0001, "gap_done");
        add(0, 0, 8'h06, 3, 2, 2, 4'b0000, "gap_after");

        // Degenerate requests finish immediately without busy or valid.
        add(0, 1, 8'hFF, 0, 4, 0, 4'b0001, "deg_len0");
        add(0, 0, 8'hFF, 0, 4, 0, 4'b0000, "deg_len0_idle");
        add(0, 1, 8'hFF, 5, 0, 0, 4'b0001, "deg_reps0");
        add(0, 0, 8'hFF, 5, 0, 0, 4'b0000, "deg_reps0_idle");

        // Length clamp to 8, with a second start and pattern change mid-transfer.
        sa5 = 8'hA5;
        add(0, 1, 8'hA5, 12, 1, 0, 4'b1110, "clamp_bit0");
        for (int i = 1; i < 8; i++) begin
            if (i == 3)
                add(0, 1, 8'hFF, 2, 1, 0, {sa5[7-i], 3'b110}, "clamp_bit_restart");
            else
                add(0, 0, (i > 3) ? 8'h00 : 8'hA5, 12, 1, 0, {sa5[7-i], 3'b110}, "clamp_bit");
        end
        add(0, 0, 8'h00, 12, 1, 0, 4'b0001, "clamp_done");
        // start during the done cycle is dropped; the very next start is accepted.
        add(0, 1, 8'hFF, 2, 1, 0, 4'b0000, "done_start_ignored");
        add(0, 1, 8'h01, 1, 1, 0, 4'b1110, "restart_after_done");
        add(0, 0, 8'h01, 1, 1, 0, 4'b0001, "restart_done");
        add(0, 0, 8'h01, 1, 1, 0, 4'b0000, "restart_idle");

        foreach (vecs[i]) begin
            rst     = vecs[i].rst;
            start   = vecs[i].start;
            pattern = vecs[i].pattern;
            len     = vecs[i].len;
            reps    = vecs[i].reps;
            gap     = vecs[i].gap;
            tick();
            check(vecs[i].name, {28'd0, a_out, valid, busy, done}, {28'd0, vecs[i].exp});
        end

        // Reset during the second repetition of a gapped transfer.
        start = 1'b1; pattern = 8'h06; len = 3; reps = 4; gap = 1;
        tick();
        check("rm_first", {a_out, valid, busy, done}, 4'b1110);
        start = 1'b0;
        tick();
        tick();
        tick();
        check("rm_gap", {a_out, valid, busy, done}, 4'b0010);
        tick();
        check("rm_rep2", {a_out, valid, busy, done}, 4'b1110);
        rst = 1'b1;
        tick();
        check("rm_abort", {a_out, valid, busy, done}, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rm_quiet", {a_out, valid, busy, done}, 4'b0000);
        end

        // A fresh transfer afterwards starts from bit len-1.
        start = 1'b1; pattern = 8'h05; len = 3; reps = 1; gap = 0;
        tick();
        start = 1'b0;
        got = '0; nbits = 0; seen_done = 1'b0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            if (valid) begin
                got = {got[6:0], a_out};
                nbits++;
            end
            if (done) seen_done = 1'b1;
            else tick();
        end
        check("rm_done_seen", seen_done, 1);
        check("rm_bit_count", nbits, 3);
        check("rm_bits", got, 8'b0000_0101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
